load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter: BASE_ADDR, 32'h01000000, first byte address of data memory.
REQ-002 SHALL have parameter: MEM_DEPTH, 1048576, data memory size in bytes.
REQ-003 SHALL have ports: clock  in  1  single clock, all state on rising edge; one clock, reset is asynchronous and active-low.
REQ-004 SHALL have port: reset_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have ports: req_valid in 1 request present; req_ready out 1 unit can accept.
REQ-006 SHALL have ports: req_addr in 32 byte address; req_wdata in 32 store data, right-aligned; req_write in 1 1=store, 0=load.
REQ-007 SHALL have ports: req_size in 2 (00 byte, 01 half, 10 word, 11 illegal); req_signed in 1 sign-extend load.
REQ-008 SHALL have ports: resp_valid out 1 completion pulse; resp_rdata out 32 load result; resp_fault out 1 request rejected.
REQ-009 SHALL have ports: mem_address out 32; mem_data_in out 32; mem_read_write out 1 (1=write); mem_access_size out 2.
REQ-010 SHALL have port: mem_data_out in 32, memory read data, combinational from mem_address, little-endian.

Function
REQ-011 SHALL implement states IDLE, RD_LO, RD_HI, WR, RESP.
REQ-012 SHALL assert req_ready only in IDLE; request accepted on edge where req_valid&&req_ready; all request fields latched then.
REQ-013 SHALL fault (IDLE->RESP, no memory access) when req_size==11 or addr<BASE_ADDR or addr+bytes>BASE_ADDR+MEM_DEPTH.
REQ-014 SHALL go IDLE->RD_LO for legal load, IDLE->WR for legal store.
REQ-015 RD_LO: drive mem_address=addr&~3, access_size=10, read_write=0; latch mem_data_out into lo word at edge.
REQ-016 RD_LO->RD_HI when (addr[1:0]+bytes)>4, else ->RESP; RD_HI drives aligned addr+4, latches hi word, ->RESP.
REQ-017 WR: drive mem_address=addr exact, mem_data_in=req_wdata, access_size=req_size, read_write=1 for exactly one cycle; ->RESP.
REQ-018 mem_read_write SHALL be 0 in every state except WR; mem_address/mem_data_in SHALL be 0 when unused.
REQ-019 RESP: resp_valid=1 for one cycle, then ->IDLE; no backpressure on response.
REQ-020 Load result = ({hi,lo} >> 8*addr[1:0]) truncated to size; byte/half sign-extended if req_signed else zero-extended; word ignores req_signed.
REQ-021 resp_rdata SHALL be 0 for stores and faults; resp_fault=1 only in RESP of a faulted request.
REQ-022 Latency acceptance->resp_valid: aligned/non-crossing load 2 cycles, crossing load 3, store 2, fault 1.
REQ-023 Maximum throughput: one request per 3 cycles (non-crossing); req_valid held low in non-IDLE states has no effect.
REQ-024 Address arithmetic SHALL be 32-bit modulo; aligned+4 computed without overflow check beyond REQ-013.

Reset
REQ-025 reset_n low SHALL immediately force state IDLE, mem_read_write 0, resp_valid 0, resp_fault 0, resp_rdata 0, req_ready 1 after release.
REQ-026 Reset mid-operation SHALL abort the request with no response; reset during WR SHALL deassert mem_read_write before next edge.
REQ-027 Latched request/data registers SHALL reset to 0.

Structure
REQ-028 Package lsu_pkg SHALL hold state enum, size encodings (SIZE_BYTE/HALF/WORD), and default BASE_ADDR/MEM_DEPTH constants.
REQ-029 One combinational sub-module lsu_load_align SHALL perform shift/extract/extend of REQ-020.

Verification
REQ-030 Word store 0xDEADBEEF at 0x01000004, then signed word load -> store resp at +2 cycles, load resp_rdata 0xDEADBEEF at +2.
REQ-031 Byte store 0x80 at 0x01000009, signed byte load -> 0xFFFFFF80; unsigned -> 0x00000080.
REQ-032 Memory words 0x44332211@0x01000010, 0x88776655@0x01000014; unsigned half load at 0x01000013 -> 0x00005544, RD_HI visited, resp at +3.
REQ-033 Load at 0x00FFFFFC, and req_size=11 at 0x01000000 -> resp_fault=1 at +1, resp_rdata 0, mem_read_write never 1.
REQ-034 Assert reset_n low during WR -> mem_read_write drops same cycle, no resp_valid, req_ready=1 after release, target memory unchanged.
REQ-035 req_valid held high continuously with alternating loads/stores -> req_ready pulses only in IDLE, each request yields exactly one resp_valid.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, access
// size encodings, default memory window and a size-to-byte-count helper.
package lsu_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_LO = 3'd1,
        RD_HI = 3'd2,
        WR    = 3'd3,
        RESP  = 3'd4
    } lsu_state_e;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_ILL  = 2'b11;

    localparam logic [31:0] DEF_BASE_ADDR = 32'h0100_0000;
    localparam int unsigned DEF_MEM_DEPTH = 32'd1048576;

    // Number of bytes touched by an access; the illegal encoding touches none.
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        logic [2:0] bytes;
        case (size)
            SIZE_BYTE: bytes = 3'd1;
            SIZE_HALF: bytes = 3'd2;
            SIZE_WORD: bytes = 3'd4;
            default:   bytes = 3'd0;
        endcase
        return bytes;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data alignment: picks the addressed bytes out of the two captured
// memory words and sign- or zero-extends them to 32 bits.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] i_lo,
    input  logic [31:0] i_hi,
    input  logic [1:0]  i_offset,
    input  logic [1:0]  i_size,
    input  logic        i_signed,
    output logic [31:0] o_rdata
);

    logic [31:0] w_shifted;

    // Little-endian window: the addressed byte lands in bit 0 after the shift.
    assign w_shifted = 32'({i_hi, i_lo} >> {i_offset, 3'b000});

    // Truncate to the access size and extend; a word ignores the signed flag.
    always_comb begin
        o_rdata = 32'h0000_0000;
        case (i_size)
            SIZE_BYTE: o_rdata = {{24{i_signed & w_shifted[7]}}, w_shifted[7:0]};
            SIZE_HALF: o_rdata = {{16{i_signed & w_shifted[15]}}, w_shifted[15:0]};
            SIZE_WORD: o_rdata = w_shifted;
            default:   o_rdata = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-request load/store unit in front of a byte-addressed, word-wide
// data memory. Loads are done as one or two aligned word reads (the second
// only when the access straddles a word boundary); stores are issued as a
// single exact-address write. Out-of-window or illegal-size requests are
// answered with a fault and never reach the memory.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
    parameter int unsigned MEM_DEPTH = DEF_MEM_DEPTH
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data_in,
    output logic        mem_read_write,
    output logic [1:0]  mem_access_size,
    input  logic [31:0] mem_data_out
);

    lsu_state_e  r_state;
    lsu_state_e  w_next_state;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_lo;
    logic [31:0] r_hi;
    logic [1:0]  r_size;
    logic        r_write;
    logic        r_signed;
    logic        r_fault;

    logic        w_accept;
    logic        w_req_fault;
    logic        w_crossing;
    logic [2:0]  w_req_bytes;
    logic [2:0]  w_span;
    logic [32:0] w_req_end;
    logic [32:0] w_limit;
    logic [31:0] w_aligned_addr;
    logic [31:0] w_align_rdata;

    assign w_accept    = (r_state == IDLE) && req_valid;
    assign w_req_bytes = size_bytes(req_size);
    // Window check is done in 33 bits so an address near 2^32 cannot wrap into range.
    assign w_req_end   = {1'b0, req_addr} + {30'd0, w_req_bytes};
    assign w_limit     = {1'b0, BASE_ADDR} + 33'(MEM_DEPTH);
    assign w_req_fault = (req_size == SIZE_ILL) || (req_addr < BASE_ADDR) || (w_req_end > w_limit);

    assign w_span         = {1'b0, r_addr[1:0]} + size_bytes(r_size);
    assign w_crossing     = (w_span > 3'd4);
    assign w_aligned_addr = {r_addr[31:2], 2'b00};

    lsu_load_align u_align (
        .i_lo     (r_lo),
        .i_hi     (r_hi),
        .i_offset (r_addr[1:0]),
        .i_size   (r_size),
        .i_signed (r_signed),
        .o_rdata  (w_align_rdata)
    );

    // State register; reset drops straight to IDLE, aborting any request.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Request capture at acceptance and memory word capture during reads.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_addr   <= 32'h0000_0000;
            r_wdata  <= 32'h0000_0000;
            r_size   <= 2'b00;
            r_write  <= 1'b0;
            r_signed <= 1'b0;
            r_fault  <= 1'b0;
            r_lo     <= 32'h0000_0000;
            r_hi     <= 32'h0000_0000;
        end else if (w_accept) begin
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
            r_size   <= req_size;
            r_write  <= req_write;
            r_signed <= req_signed;
            r_fault  <= w_req_fault;
            r_lo     <= 32'h0000_0000;
            r_hi     <= 32'h0000_0000;
        end else if (r_state == RD_LO) begin
            r_lo <= mem_data_out;
        end else if (r_state == RD_HI) begin
            r_hi <= mem_data_out;
        end else begin
            r_lo <= r_lo;
        end
    end

    // Next-state selection.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (!req_valid) begin
                    w_next_state = IDLE;
                end else if (w_req_fault) begin
                    w_next_state = RESP;
                end else if (req_write) begin
                    w_next_state = WR;
                end else begin
                    w_next_state = RD_LO;
                end
            end
            RD_LO: begin
                if (w_crossing) begin
                    w_next_state = RD_HI;
                end else begin
                    w_next_state = RESP;
                end
            end
            RD_HI:   w_next_state = RESP;
            WR:      w_next_state = RESP;
            RESP:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Outputs decoded from the state register so reset clears them at once.
    always_comb begin
        req_ready       = 1'b0;
        resp_valid      = 1'b0;
        resp_fault      = 1'b0;
        resp_rdata      = 32'h0000_0000;
        mem_address     = 32'h0000_0000;
        mem_data_in     = 32'h0000_0000;
        mem_read_write  = 1'b0;
        mem_access_size = 2'b00;
        case (r_state)
            IDLE: req_ready = 1'b1;
            RD_LO: begin
                mem_address     = w_aligned_addr;
                mem_access_size = SIZE_WORD;
            end
            RD_HI: begin
                mem_address     = w_aligned_addr + 32'd4;
                mem_access_size = SIZE_WORD;
            end
            WR: begin
                mem_address     = r_addr;
                mem_data_in     = r_wdata;
                mem_access_size = r_size;
                mem_read_write  = 1'b1;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_fault = r_fault;
                if (r_fault || r_write) begin
                    resp_rdata = 32'h0000_0000;
                end else begin
                    resp_rdata = w_align_rdata;
                end
            end
            default: req_ready = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: byte-level reference memory and
// request model, a per-cycle compare process, directed pinned cases and a
// randomized back-to-back request phase.
module tb_load_store_unit;

    localparam logic [31:0] BASE  = 32'h0100_0000;
    localparam logic [63:0] DEPTH = 64'd1048576;
    localparam logic [31:0] TOP   = 32'h0110_0000;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic [31:0] mem_address;
    logic [31:0] mem_data_in;
    logic        mem_read_write;
    logic [1:0]  mem_access_size;
    logic [31:0] mem_data_out = 32'h0;

    always #5 clock = ~clock;

    load_store_unit #(.BASE_ADDR(BASE), .MEM_DEPTH(1048576)) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .req_write       (req_write),
        .req_size        (req_size),
        .req_signed      (req_signed),
        .resp_valid      (resp_valid),
        .resp_rdata      (resp_rdata),
        .resp_fault      (resp_fault),
        .mem_address     (mem_address),
        .mem_data_in     (mem_data_in),
        .mem_read_write  (mem_read_write),
        .mem_access_size (mem_access_size),
        .mem_data_out    (mem_data_out)
    );

    logic [7:0] env_mem [logic [31:0]];
    logic [7:0] ref_mem [logic [31:0]];

    int n_pass = 0;
    int n_total = 0;

    int busy_until = -1;
    int exp_resp_edge = -1;
    int exp_wr_edge = -1;
    int edge_cnt;
    int acc_cnt = 0;
    int resp_cnt = 0;
    bit chk_en = 1'b0;
    logic        exp_fault = 1'b0;
    logic [31:0] exp_rdata = 32'h0;
    logic [31:0] exp_wr_addr = 32'h0;
    logic [31:0] exp_wr_data = 32'h0;
    logic [1:0]  exp_wr_size = 2'b00;

    function automatic int nbytes(input logic [1:0] s);
        return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : (s == 2'b10) ? 4 : 0;
    endfunction

    function automatic logic [7:0] env_rd(input logic [31:0] a);
        if (env_mem.exists(a)) return env_mem[a];
        return 8'h00;
    endfunction

    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return 8'h00;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Edges since the last reset release: the model's notion of time.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) edge_cnt <= 0;
        else          edge_cnt <= edge_cnt + 1;
    end

    // Data memory seen by the DUT: writes during a write cycle, reads for the next edge.
    always @(negedge clock) begin
        if (mem_read_write) begin
            for (int i = 0; i < nbytes(mem_access_size); i++)
                env_mem[mem_address + 32'(i)] = mem_data_in[8*i +: 8];
        end
        mem_data_out = {env_rd(mem_address + 32'd3), env_rd(mem_address + 32'd2),
                        env_rd(mem_address + 32'd1), env_rd(mem_address)};
    end

    // Model a request accepted at the edge just passed.
    task automatic model_accept(input logic w, input logic [1:0] sz, input logic sg,
                                input logic [31:0] addr, input logic [31:0] wdata);
        int nb;
        int lat;
        int a;
        logic [63:0] e;
        logic flt;
        logic [31:0] v;
        a  = edge_cnt;
        nb = nbytes(sz);
        e  = {32'h0, addr} + 64'(nb);
        flt = (sz == 2'b11) || (addr < BASE) || (e > ({32'h0, BASE} + DEPTH));
        v = 32'h0;
        if (flt) begin
            lat = 1;
        end else if (w) begin
            lat = 2;
            exp_wr_edge = a;
            exp_wr_addr = addr;
            exp_wr_data = wdata;
            exp_wr_size = sz;
            for (int i = 0; i < nb; i++) ref_mem[addr + 32'(i)] = wdata[8*i +: 8];
        end else begin
            lat = ((int'(addr[1:0]) + nb) > 4) ? 3 : 2;
            for (int i = 0; i < nb; i++) v = v | (32'(ref_rd(addr + 32'(i))) << (8*i));
            if (sg && nb < 4 && v[8*nb-1]) v = v | ~((32'h1 << (8*nb)) - 32'h1);
        end
        exp_fault     = flt;
        exp_rdata     = v;
        exp_resp_edge = a + lat - 1;
        busy_until    = exp_resp_edge;
        acc_cnt++;
    endtask

    // Per-cycle comparison of every observable output against the model.
    always @(negedge clock) begin
        if (chk_en && reset_n) begin
            check("req_ready", 32'(req_ready), 32'(edge_cnt > busy_until));
            check("resp_valid", 32'(resp_valid), 32'(edge_cnt == exp_resp_edge));
            if (edge_cnt == exp_resp_edge) begin
                check("resp_fault", 32'(resp_fault), 32'(exp_fault));
                check("resp_rdata", resp_rdata, exp_rdata);
            end
            if (resp_valid) resp_cnt++;
            check("mem_read_write", 32'(mem_read_write), 32'(edge_cnt == exp_wr_edge));
            if (edge_cnt == exp_wr_edge) begin
                check("wr_address", mem_address, exp_wr_addr);
                check("wr_data", mem_data_in, exp_wr_data);
                check("wr_size", 32'(mem_access_size), 32'(exp_wr_size));
            end
        end
    end

    // One request on an idle unit; returns the observed latency and response.
    task automatic issue(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output int lat, output logic [31:0] rdata, output logic flt);
        bit rdy;
        @(negedge clock);
        req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
        req_addr = addr; req_wdata = wdata;
        rdy = (edge_cnt > busy_until);
        @(posedge clock); #1;
        req_valid = 1'b0;
        if (rdy) model_accept(w, sz, sg, addr, wdata);
        lat = 1;
        @(negedge clock);
        while (!resp_valid && lat < 8) begin
            @(negedge clock);
            lat++;
        end
        rdata = resp_rdata;
        flt   = resp_fault;
        if (!resp_valid) lat = 99;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic [31:0] rd;
        logic f;
        bit rdy;

        // Reset state.
        repeat (3) @(negedge clock);
        check("rst_resp_valid", 32'(resp_valid), 32'h0);
        check("rst_resp_fault", 32'(resp_fault), 32'h0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        check("rst_mem_rw", 32'(mem_read_write), 32'h0);
        reset_n = 1'b1;
        @(posedge clock); #1;
        chk_en = 1'b1;
        check("rst_req_ready", 32'(req_ready), 32'h1);

        // Word store then signed word load.
        issue(1'b1, 2'b10, 1'b0, 32'h0100_0004, 32'hDEAD_BEEF, lat, rd, f);
        check("st_word_lat", 32'(lat), 32'd2);
        check("st_word_fault", 32'(f), 32'h0);
        check("st_word_rdata", rd, 32'h0);
        issue(1'b0, 2'b10, 1'b1, 32'h0100_0004, 32'h0, lat, rd, f);
        check("ld_word_lat", 32'(lat), 32'd2);
        check("ld_word_rdata", rd, 32'hDEAD_BEEF);

        // Byte store, signed and unsigned byte loads.
        issue(1'b1, 2'b00, 1'b0, 32'h0100_0009, 32'h0000_0080, lat, rd, f);
        issue(1'b0, 2'b00, 1'b1, 32'h0100_0009, 32'h0, lat, rd, f);
        check("ld_sbyte_rdata", rd, 32'hFFFF_FF80);
        issue(1'b0, 2'b00, 1'b0, 32'h0100_0009, 32'h0, lat, rd, f);
        check("ld_ubyte_rdata", rd, 32'h0000_0080);

        // Word-crossing loads.
        issue(1'b1, 2'b10, 1'b0, 32'h0100_0010, 32'h4433_2211, lat, rd, f);
        issue(1'b1, 2'b10, 1'b0, 32'h0100_0014, 32'h8877_6655, lat, rd, f);
        issue(1'b0, 2'b01, 1'b0, 32'h0100_0013, 32'h0, lat, rd, f);
        check("ld_cross_half_lat", 32'(lat), 32'd3);
        check("ld_cross_half_rdata", rd, 32'h0000_5544);
        issue(1'b0, 2'b10, 1'b0, 32'h0100_0011, 32'h0, lat, rd, f);
        check("ld_cross_word_rdata", rd, 32'h5544_3322);

        // Faults and window edges.
        issue(1'b0, 2'b10, 1'b0, 32'h00FF_FFFC, 32'h0, lat, rd, f);
        check("flt_low_lat", 32'(lat), 32'd1);
        check("flt_low_fault", 32'(f), 32'h1);
        check("flt_low_rdata", rd, 32'h0);
        issue(1'b0, 2'b11, 1'b0, 32'h0100_0000, 32'h0, lat, rd, f);
        check("flt_size_fault", 32'(f), 32'h1);
        check("flt_size_lat", 32'(lat), 32'd1);
        issue(1'b0, 2'b10, 1'b0, TOP - 32'd4, 32'h0, lat, rd, f);
        check("top_word_ok", 32'(f), 32'h0);
        issue(1'b0, 2'b10, 1'b0, TOP - 32'd2, 32'h0, lat, rd, f);
        check("top_word_fault", 32'(f), 32'h1);
        issue(1'b0, 2'b01, 1'b0, TOP - 32'd2, 32'h0, lat, rd, f);
        check("top_half_ok", 32'(f), 32'h0);

        // Reset during the write cycle aborts the store.
        @(negedge clock);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_signed = 1'b0;
        req_addr = 32'h0100_0020; req_wdata = 32'h1234_5678;
        @(posedge clock); #1;
        req_valid = 1'b0;
        chk_en = 1'b0;
        #1;
        check("abort_wr_active", 32'(mem_read_write), 32'h1);
        reset_n = 1'b0;
        #1;
        check("abort_wr_dropped", 32'(mem_read_write), 32'h0);
        check("abort_no_resp", 32'(resp_valid), 32'h0);
        busy_until = -1; exp_resp_edge = -1; exp_wr_edge = -1;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock); #1;
        chk_en = 1'b1;
        check("abort_ready", 32'(req_ready), 32'h1);
        check("abort_mem_kept", {env_rd(32'h0100_0023), env_rd(32'h0100_0022),
                                 env_rd(32'h0100_0021), env_rd(32'h0100_0020)}, 32'h0);
        issue(1'b0, 2'b10, 1'b0, 32'h0100_0020, 32'h0, lat, rd, f);
        check("abort_readback", rd, 32'h0);

        // Randomized, mostly back-to-back requests with fields changing every cycle.
        for (int n = 0; n < 800; n++) begin
            @(negedge clock);
            req_valid  = ($urandom_range(0, 9) != 0);
            req_write  = 1'($urandom_range(0, 1));
            req_size   = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            req_signed = 1'($urandom_range(0, 1));
            req_wdata  = $urandom;
            case ($urandom_range(0, 9))
                0:       req_addr = BASE - 32'($urandom_range(1, 4));
                1:       req_addr = TOP - 32'($urandom_range(1, 5));
                default: req_addr = BASE + 32'($urandom_range(0, 47));
            endcase
            rdy = (edge_cnt > busy_until);
            @(posedge clock); #1;
            if (req_valid && rdy) model_accept(req_write, req_size, req_signed, req_addr, req_wdata);
        end
        @(negedge clock);
        req_valid = 1'b0;
        repeat (6) @(negedge clock);
        check("resp_count", 32'(resp_cnt), 32'(acc_cnt));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
